axis_update_scheduler: RTL

- Sequencer for the spaceship position datapath.
- A single 16-bit add/sub ripple-carry unit is shared, time-multiplexed, across the x, y and z axis position registers.
- On each update tick the block steps through the three axes, driving:
  - mode-mux one-hot select (velocity source);
  - position-mux one-hot select (reset / normal / warp);
  - add/subtract mode;
  - per-axis write enables.
- Also owns the mode register, command handshake and warp cooldown.

---
 rtl/ship_ctrl_pkg.sv | 40 ++++
 rtl/warp_cooldown_timer.sv | 50 +++++
 rtl/axis_update_scheduler.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/ship_ctrl_pkg.sv
// ============================================================================
// Module   : ship_ctrl_pkg
// Purpose  : Shared encodings for the spaceship position-datapath sequencer.
//            Holds the mode encodings, the one-hot select constants used on
//            mode_sel/pos_sel, and the scheduler state encoding.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ship_ctrl_pkg;

  // Command / mode register encodings
  localparam logic [1:0] MODE_RESET   = 2'd0;
  localparam logic [1:0] MODE_ATTACK  = 2'd1;
  localparam logic [1:0] MODE_DEFENSE = 2'd2;
  localparam logic [1:0] MODE_STEALTH = 2'd3;

  // One-hot select patterns (position mux and velocity mux)
  localparam logic [3:0] SEL_IDLE   = 4'b0000;
  localparam logic [3:0] SEL_RESET  = 4'b0001;
  localparam logic [3:0] SEL_NORMAL = 4'b0010;
  localparam logic [3:0] SEL_WARP   = 4'b0100;

  // Scheduler states; every non-idle state lasts exactly one cycle
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_UPD_X = 3'd2,
    ST_UPD_Y = 3'd3,
    ST_UPD_Z = 3'd4
  } state_t;

  // Mode encoding -> one-hot velocity select (reset=0001 ... stealth=1000)
  function automatic logic [3:0] mode_onehot(input logic [1:0] mode);
    return 4'(1) << mode;
  endfunction

endpackage

`default_nettype wire

// File: rtl/warp_cooldown_timer.sv
// ============================================================================
// Module   : warp_cooldown_timer
// Purpose  : Frame-based warp cooldown counter. Loads WARP_COOLDOWN after a
//            warp frame, decrements (saturating at 0) after a normal frame,
//            and is cleared by a reset-mode command.
// Ports    : clk, rst_n       - clock, async active-low reset
//            i_clr            - force count to zero
//            i_load           - load WARP_COOLDOWN (warp frame ended)
//            i_dec            - decrement, saturating (normal frame ended)
//            o_zero           - count == 0
//            o_le_one         - count <= 1 (zero once a pending decrement lands)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module warp_cooldown_timer #(
  parameter int CNT_W         = 4,
  parameter int WARP_COOLDOWN = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_load,
  input  logic i_dec,
  output logic o_zero,
  output logic o_le_one
);

  localparam logic [CNT_W-1:0] c_LOAD = CNT_W'(WARP_COOLDOWN);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= c_LOAD;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero   = (r_cnt == '0);
  assign o_le_one = (r_cnt <= CNT_W'(1));

endmodule

`default_nettype wire

// File: rtl/axis_update_scheduler.sv
// ============================================================================
// Module   : axis_update_scheduler
// Purpose  : Sequencer for the spaceship position datapath. Time-multiplexes
//            one shared add/sub unit across the x, y, z position registers,
//            owns the mode register, the command handshake and warp cooldown.
// Ports    : clk, rst_n        - clock, async active-low reset
//            i_tick            - frame update request (1-cycle pulse)
//            i_cmd_valid/o_cmd_ready, i_cmd_mode - mode command handshake
//            i_warp_req        - request warp for the next frame
//            i_dir_neg[2:0]    - per-axis subtract select ([0]=x)
//            o_mode_sel        - one-hot velocity source select
//            o_pos_sel         - one-hot position source select
//            o_axis_we         - per-axis position write enable
//            o_add_sub_mode    - shared adder mode (1 = subtract)
//            o_busy, o_warp_active, o_overrun - status
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module axis_update_scheduler
  import ship_ctrl_pkg::*;
#(
  parameter int WARP_COOLDOWN = 8,
  parameter int CNT_W         = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_tick,
  input  logic       i_cmd_valid,
  input  logic [1:0] i_cmd_mode,
  output logic       o_cmd_ready,
  input  logic       i_warp_req,
  input  logic [2:0] i_dir_neg,
  output logic [3:0] o_mode_sel,
  output logic [3:0] o_pos_sel,
  output logic [2:0] o_axis_we,
  output logic       o_add_sub_mode,
  output logic       o_busy,
  output logic       o_warp_active,
  output logic       o_overrun
);

  state_t     r_state;
  logic [1:0] r_mode;
  logic       r_pending;
  logic       r_warp;
  logic       r_overrun;
  logic       r_busy;
  logic [3:0] r_pos_sel;
  logic [2:0] r_axis_we;
  logic       r_add_sub;

  logic w_ready;
  logic w_accept;
  logic w_warp_mode;
  logic w_cd_zero;
  logic w_cd_le_one;
  logic w_grant;
  logic w_frame_end;

  assign w_ready     = (r_state == ST_IDLE) && !r_pending;
  assign w_accept    = i_cmd_valid && w_ready;
  assign w_warp_mode = (r_mode == MODE_ATTACK) || (r_mode == MODE_DEFENSE);
  assign w_frame_end = (r_state == ST_UPD_Z);

  // When chaining straight out of UPD_Z the cooldown update of the ending
  // frame lands on the same edge, so judge against the post-update value:
  // a warp frame reloads the counter, a normal frame brings 1 down to 0.
  always_comb begin
    w_grant = 1'b0;
    if (i_warp_req && w_warp_mode) begin
      if (r_state == ST_UPD_Z) w_grant = !r_warp && w_cd_le_one;
      else                     w_grant = w_cd_zero;
    end
  end

  warp_cooldown_timer #(
    .CNT_W         (CNT_W),
    .WARP_COOLDOWN (WARP_COOLDOWN)
  ) u_cooldown (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clr    (w_accept && (i_cmd_mode == MODE_RESET)),
    .i_load   (w_frame_end && r_warp),
    .i_dec    (w_frame_end && !r_warp),
    .o_zero   (w_cd_zero),
    .o_le_one (w_cd_le_one)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_mode    <= MODE_RESET;
      r_pending <= 1'b0;
      r_warp    <= 1'b0;
      r_overrun <= 1'b0;
      r_busy    <= 1'b0;
      r_pos_sel <= SEL_IDLE;
      r_axis_we <= 3'b000;
      r_add_sub <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_mode    <= i_cmd_mode;
            // A tick coinciding with an accepted command is deferred
            r_pending <= i_tick;
            if (i_cmd_mode == MODE_RESET) begin
              r_state   <= ST_CLEAR;
              r_pos_sel <= SEL_RESET;
              r_axis_we <= 3'b111;
              r_busy    <= 1'b1;
            end
          end else if (i_tick || r_pending) begin
            r_state   <= ST_UPD_X;
            r_warp    <= w_grant;
            r_pos_sel <= w_grant ? SEL_WARP : SEL_NORMAL;
            r_axis_we <= 3'b001;
            r_add_sub <= i_dir_neg[0];
            r_busy    <= 1'b1;
            // Consume the pending request; a fresh tick re-queues it
            r_pending <= r_pending && i_tick;
          end
        end

        ST_CLEAR: begin
          if (r_pending) begin
            r_state   <= ST_UPD_X;
            r_pending <= 1'b0;
            r_warp    <= w_grant;
            r_pos_sel <= w_grant ? SEL_WARP : SEL_NORMAL;
            r_axis_we <= 3'b001;
            r_add_sub <= i_dir_neg[0];
          end else begin
            r_state   <= ST_IDLE;
            r_pos_sel <= SEL_IDLE;
            r_axis_we <= 3'b000;
            r_busy    <= 1'b0;
          end
        end

        ST_UPD_X: begin
          r_state   <= ST_UPD_Y;
          r_axis_we <= 3'b010;
          r_add_sub <= i_dir_neg[1];
        end

        ST_UPD_Y: begin
          r_state   <= ST_UPD_Z;
          r_axis_we <= 3'b100;
          r_add_sub <= i_dir_neg[2];
        end

        ST_UPD_Z: begin
          if (r_pending) begin
            // Back-to-back frame with no idle cycle in between
            r_state   <= ST_UPD_X;
            r_pending <= 1'b0;
            r_warp    <= w_grant;
            r_pos_sel <= w_grant ? SEL_WARP : SEL_NORMAL;
            r_axis_we <= 3'b001;
            r_add_sub <= i_dir_neg[0];
          end else begin
            r_state   <= ST_IDLE;
            r_warp    <= 1'b0;
            r_pos_sel <= SEL_IDLE;
            r_axis_we <= 3'b000;
            r_add_sub <= 1'b0;
            r_busy    <= 1'b0;
          end
        end

        default: begin
          r_state   <= ST_IDLE;
          r_warp    <= 1'b0;
          r_pos_sel <= SEL_IDLE;
          r_axis_we <= 3'b000;
          r_add_sub <= 1'b0;
          r_busy    <= 1'b0;
        end
      endcase

      // Ticks arriving while busy: queue one, drop and flag any further one.
      // Placed after the case so it wins over a same-edge pending clear only
      // when nothing was queued yet.
      if ((r_state != ST_IDLE) && i_tick) begin
        if (r_pending) r_overrun <= 1'b1;
        else           r_pending <= 1'b1;
      end
    end
  end

  assign o_cmd_ready    = w_ready;
  assign o_mode_sel     = mode_onehot(r_mode);
  assign o_pos_sel      = r_pos_sel;
  assign o_axis_we      = r_axis_we;
  assign o_add_sub_mode = r_add_sub;
  assign o_busy         = r_busy;
  assign o_warp_active  = r_warp;
  assign o_overrun      = r_overrun;

endmodule

`default_nettype wire
